// File: rtl/sp3_mux_tx.sv
`default_nettype none
// ============================================================================
//  Module   : sp3_mux_tx
//  Brief    : Two-stream lpGBT frame interleaver for an MGT transmitter.
//             A 2-entry pair FIFO feeds a two-phase loader; each 32-bit word
//             pair is emitted as two bit-interleaved MGT words (low half,
//             then high half), with per-stream programmable bit slip.
//  Revision : 1.0 - initial release
// ============================================================================
module sp3_mux_tx #(
    parameter logic [31:0] IDLE_A = 32'h0000_0000,
    parameter logic [31:0] IDLE_B = 32'h0000_0000
) (
    input  logic        mgtclk,
    input  logic        reset,
    input  logic [31:0] word_a,
    input  logic [31:0] word_b,
    input  logic        word_valid,
    output logic        word_ready,
    input  logic        slip_a,
    input  logic        slip_b,
    output logic [31:0] mgtword,
    output logic        tx_phase,
    output logic [4:0]  slip_a_val,
    output logic [4:0]  slip_b_val,
    output logic [15:0] underflow_count
);

    localparam logic [1:0]  FIFO_DEPTH = 2'd2;
    localparam logic [15:0] UF_MAX     = 16'hFFFF;

    // FIFO storage: each entry is {word_a, word_b}
    logic [63:0] fifo_mem_q [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  occ_q,    occ_d;

    logic        tx_phase_q;
    logic [31:0] cur_a_q,  cur_a_d;
    logic [31:0] cur_b_q,  cur_b_d;
    logic [31:0] prev_a_q, prev_a_d;
    logic [31:0] prev_b_q, prev_b_d;
    logic [4:0]  act_a_q,  act_a_d;
    logic [4:0]  act_b_q,  act_b_d;

    logic        slip_a_q, slip_b_q;
    logic [4:0]  slip_a_val_q, slip_a_val_d;
    logic [4:0]  slip_b_val_q, slip_b_val_d;
    logic [15:0] uf_q,     uf_d;
    logic [31:0] mgtword_q, mgtword_d;

    logic        push;
    logic        pop;
    logic        load;
    logic [63:0] head;
    logic [63:0] hist_a;
    logic [63:0] hist_b;
    logic [31:0] sa;
    logic [31:0] sb;

    // Ready depends only on registered occupancy to keep the handshake timing-clean
    assign word_ready = (occ_q < FIFO_DEPTH);
    assign push       = word_valid && word_ready;
    assign load       = !tx_phase_q;
    // A pair pushed on this edge is not visible to this edge's pop (uses occ_q)
    assign pop        = load && (occ_q != 2'd0);
    assign head       = fifo_mem_q[rd_ptr_q];

    // Slipped word: 32-bit window of {prev, cur} starting act bits up from cur[0]
    assign hist_a = {prev_a_q, cur_a_q};
    assign hist_b = {prev_b_q, cur_b_q};
    assign sa     = 32'(hist_a >> act_a_q);
    assign sb     = 32'(hist_b >> act_b_q);

    // FIFO pointer and occupancy bookkeeping
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // Phase-0 load of the cur/prev history, active slip and underflow count
    always_comb begin
        cur_a_d  = cur_a_q;
        cur_b_d  = cur_b_q;
        prev_a_d = prev_a_q;
        prev_b_d = prev_b_q;
        act_a_d  = act_a_q;
        act_b_d  = act_b_q;
        uf_d     = uf_q;
        if (load) begin
            prev_a_d = cur_a_q;
            prev_b_d = cur_b_q;
            act_a_d  = slip_a_val_q;
            act_b_d  = slip_b_val_q;
            if (occ_q != 2'd0) begin
                cur_a_d = head[63:32];
                cur_b_d = head[31:0];
            end else begin
                cur_a_d = IDLE_A;
                cur_b_d = IDLE_B;
                if (uf_q != UF_MAX) begin
                    uf_d = uf_q + 16'd1;
                end
            end
        end
    end

    // Slip counters advance once per rising edge of the request
    always_comb begin
        slip_a_val_d = slip_a_val_q;
        slip_b_val_d = slip_b_val_q;
        if (slip_a && !slip_a_q) begin
            slip_a_val_d = slip_a_val_q + 5'd1;
        end
        if (slip_b && !slip_b_q) begin
            slip_b_val_d = slip_b_val_q + 5'd1;
        end
    end

    // Bit interleave: phase 1 sends the low halves, phase 0 the high halves
    always_comb begin
        mgtword_d = '0;
        for (int i = 0; i < 16; i++) begin
            if (tx_phase_q) begin
                mgtword_d[2*i]   = sa[i];
                mgtword_d[2*i+1] = sb[i];
            end else begin
                mgtword_d[2*i]   = sa[16+i];
                mgtword_d[2*i+1] = sb[16+i];
            end
        end
    end

    // FIFO data storage (no reset needed; occupancy gates all reads)
    always_ff @(posedge mgtclk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {word_a, word_b};
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge mgtclk) begin
        if (reset) begin
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            occ_q        <= 2'd0;
            tx_phase_q   <= 1'b0;
            cur_a_q      <= '0;
            cur_b_q      <= '0;
            prev_a_q     <= '0;
            prev_b_q     <= '0;
            act_a_q      <= '0;
            act_b_q      <= '0;
            slip_a_q     <= 1'b0;
            slip_b_q     <= 1'b0;
            slip_a_val_q <= '0;
            slip_b_val_q <= '0;
            uf_q         <= '0;
            mgtword_q    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            tx_phase_q   <= ~tx_phase_q;
            cur_a_q      <= cur_a_d;
            cur_b_q      <= cur_b_d;
            prev_a_q     <= prev_a_d;
            prev_b_q     <= prev_b_d;
            act_a_q      <= act_a_d;
            act_b_q      <= act_b_d;
            slip_a_q     <= slip_a;
            slip_b_q     <= slip_b;
            slip_a_val_q <= slip_a_val_d;
            slip_b_val_q <= slip_b_val_d;
            uf_q         <= uf_d;
            mgtword_q    <= mgtword_d;
        end
    end

    assign mgtword         = mgtword_q;
    assign tx_phase        = tx_phase_q;
    assign slip_a_val      = slip_a_val_q;
    assign slip_b_val      = slip_b_val_q;
    assign underflow_count = uf_q;

endmodule
`default_nettype wire

// File: tb/tb_sp3_mux_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sp3_mux_tx
//  Brief    : Self-checking bench for sp3_mux_tx. Edges after reset release
//             are numbered 0,1,2,...; even-numbered edges are loads. Expected
//             MGT words are queued with the edge number they must follow.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sp3_mux_tx;

    logic        mgtclk;
    logic        reset;
    logic [31:0] word_a;
    logic [31:0] word_b;
    logic        word_valid;
    logic        word_ready;
    logic        slip_a;
    logic        slip_b;
    logic [31:0] mgtword;
    logic        tx_phase;
    logic [4:0]  slip_a_val;
    logic [4:0]  slip_b_val;
    logic [15:0] underflow_count;

    sp3_mux_tx dut (
        .mgtclk          (mgtclk),
        .reset           (reset),
        .word_a          (word_a),
        .word_b          (word_b),
        .word_valid      (word_valid),
        .word_ready      (word_ready),
        .slip_a          (slip_a),
        .slip_b          (slip_b),
        .mgtword         (mgtword),
        .tx_phase        (tx_phase),
        .slip_a_val      (slip_a_val),
        .slip_b_val      (slip_b_val),
        .underflow_count (underflow_count)
    );

    initial mgtclk = 1'b0;
    always #5 mgtclk = ~mgtclk;

    typedef struct {
        int          e;
        logic [31:0] v;
        string       nm;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic add_exp(input int e, input logic [31:0] v, input string nm);
        exp_t x;
        x.e  = e;
        x.v  = v;
        x.nm = nm;
        sbq.push_back(x);
    endtask

    // Reference interleave of one 16-bit half of two words
    function automatic logic [31:0] ilv(input logic [31:0] x, input logic [31:0] y, input bit hi);
        logic [31:0] r;
        int          off;
        r   = '0;
        off = hi ? 16 : 0;
        for (int i = 0; i < 16; i++) begin
            r[2*i]   = x[i+off];
            r[2*i+1] = y[i+off];
        end
        return r;
    endfunction

    // Monitor: numbers edges, checks phase and pops due scoreboard entries
    always @(posedge mgtclk) begin
        logic r;
        exp_t x;
        r = reset;
        #1;
        if (r) begin
            cyc = -1;
        end else begin
            cyc = cyc + 1;
            chk("tx_phase_toggle", {31'b0, tx_phase}, (cyc % 2 == 0) ? 32'd1 : 32'd0);
            while (sbq.size() > 0 && sbq[0].e <= cyc) begin
                x = sbq.pop_front();
                if (x.e < cyc) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL %s: missed slot at edge %0d, expected %h", x.nm, x.e, x.v);
                end else begin
                    chk(x.nm, mgtword, x.v);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge mgtclk);
        reset = 1'b1;
        repeat (2) @(negedge mgtclk);
        reset = 1'b0;
    endtask

    task automatic goto_odd();
        while ((cyc + 1) % 2 != 1) @(negedge mgtclk);
    endtask

    task automatic drain(input string nm);
        int guard;
        guard = 0;
        while (sbq.size() > 0 && guard < 40) begin
            @(negedge mgtclk);
            guard++;
        end
        chk(nm, sbq.size(), 0);
    endtask

    vec_t        tbl [8];
    logic [31:0] bp_a [5];
    logic [31:0] bp_b [5];
    logic        rdy_log [8];
    int          p;
    int          idx;

    initial begin
        reset      = 1'b1;
        word_a     = '0;
        word_b     = '0;
        word_valid = 1'b0;
        slip_a     = 1'b0;
        slip_b     = 1'b0;

        tbl[0] = '{32'h0000_FFFF, 32'h0000_0000, 32'h5555_5555, 32'h0000_0000};
        tbl[1] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'hAAAA_AAAA};
        tbl[2] = '{32'hFFFF_0000, 32'h0000_0000, 32'h0000_0000, 32'h5555_5555};
        tbl[3] = '{32'h0000_0000, 32'h0000_FFFF, 32'hAAAA_AAAA, 32'h0000_0000};
        tbl[4] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0003, 32'h0000_0000};
        tbl[5] = '{32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 32'h4000_0000};
        tbl[6] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000};
        tbl[7] = '{32'h0000_000F, 32'h0000_00F0, 32'h0000_AA55, 32'h0000_0000};

        for (int k = 0; k < 5; k++) begin
            bp_a[k] = 32'h1111_1111 * (k + 1);
            bp_b[k] = {16'(k * 7 + 1), 16'hA5A5};
        end

        // Reset state
        do_reset();
        chk("rst_mgtword", mgtword, 32'h0);
        chk("rst_tx_phase", {31'b0, tx_phase}, 32'd0);
        chk("rst_ready", {31'b0, word_ready}, 32'd1);
        chk("rst_slip_a", {27'b0, slip_a_val}, 32'd0);
        chk("rst_slip_b", {27'b0, slip_b_val}, 32'd0);
        chk("rst_underflow", {16'b0, underflow_count}, 32'd0);

        // Underflow: 8 edges with no traffic
        for (int k = 0; k < 8; k++) add_exp(k, 32'h0, "idle_word");
        repeat (8) @(negedge mgtclk);
        chk("underflow_after8", {16'b0, underflow_count}, 32'd4);
        chk("phase_after8", {31'b0, tx_phase}, 32'd0);

        // Table vectors, one pair per frame, slip = 0
        goto_odd();
        for (int j = 0; j < 8; j++) begin
            p = cyc + 1;
            chk("tbl_ready", {31'b0, word_ready}, 32'd1);
            word_valid = 1'b1;
            word_a     = tbl[j].a;
            word_b     = tbl[j].b;
            add_exp(p + 2, tbl[j].lo, $sformatf("tbl%0d_lo", j));
            add_exp(p + 3, tbl[j].hi, $sformatf("tbl%0d_hi", j));
            @(negedge mgtclk);
            word_valid = 1'b0;
            @(negedge mgtclk);
        end
        drain("tbl_drain");

        // Backpressure: valid held across 5 distinct pairs
        goto_odd();
        p = cyc + 1;
        for (int j = 0; j < 5; j++) begin
            add_exp(p + 2 + 2 * j, ilv(bp_a[j], bp_b[j], 1'b0), $sformatf("bp%0d_lo", j));
            add_exp(p + 3 + 2 * j, ilv(bp_a[j], bp_b[j], 1'b1), $sformatf("bp%0d_hi", j));
        end
        idx = 0;
        for (int k = 0; k < 8; k++) begin
            if (idx < 5) begin
                word_valid = 1'b1;
                word_a     = bp_a[idx];
                word_b     = bp_b[idx];
            end else begin
                word_valid = 1'b0;
            end
            rdy_log[k] = word_ready;
            @(posedge mgtclk);
            if (word_valid && rdy_log[k]) idx++;
            @(negedge mgtclk);
        end
        word_valid = 1'b0;
        chk("bp_accepted", idx, 5);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("bp_ready%0d", k), {31'b0, rdy_log[k]},
                (k == 3 || k == 5 || k == 7) ? 32'd0 : 32'd1);
        end
        drain("bp_drain");

        // Slip A: held-high request counts once, then a two-pair pattern
        slip_a = 1'b1;
        repeat (3) @(negedge mgtclk);
        slip_a = 1'b0;
        @(negedge mgtclk);
        chk("slip_a_once", {27'b0, slip_a_val}, 32'd1);
        chk("slip_b_untouched", {27'b0, slip_b_val}, 32'd0);
        goto_odd();
        p = cyc + 1;
        add_exp(p + 2, 32'h0, "slip_p1_lo");
        add_exp(p + 3, 32'h0, "slip_p1_hi");
        add_exp(p + 4, 32'h0, "slip_p2_lo");
        add_exp(p + 5, 32'h4000_0000, "slip_p2_hi");
        word_valid = 1'b1;
        word_a     = 32'h1;
        word_b     = 32'h0;
        @(negedge mgtclk);
        word_valid = 1'b0;
        @(negedge mgtclk);
        word_valid = 1'b1;
        word_a     = 32'h0;
        word_b     = 32'h0;
        @(negedge mgtclk);
        word_valid = 1'b0;
        drain("slip_drain");

        // Reset between the two halves of a frame
        do_reset();
        chk("rst2_slip_a", {27'b0, slip_a_val}, 32'd0);
        chk("rst2_underflow", {16'b0, underflow_count}, 32'd0);
        @(negedge mgtclk);
        word_valid = 1'b1;
        word_a     = 32'hFFFF_FFFF;
        word_b     = 32'hFFFF_FFFF;
        add_exp(3, 32'hFFFF_FFFF, "mid_lo");
        @(negedge mgtclk);
        word_valid = 1'b0;
        repeat (2) @(negedge mgtclk);
        reset = 1'b1;
        @(negedge mgtclk);
        chk("mid_rst_mgtword", mgtword, 32'h0);
        chk("mid_rst_phase", {31'b0, tx_phase}, 32'd0);
        chk("mid_rst_ready", {31'b0, word_ready}, 32'd1);
        reset = 1'b0;
        @(negedge mgtclk);
        chk("mid_after_mgtword", mgtword, 32'h0);
        chk("mid_after_underflow", {16'b0, underflow_count}, 32'd1);

        // 32 slip_b pulses wrap to 0; first pulse also hits slip_a
        for (int k = 0; k < 32; k++) begin
            slip_b = 1'b1;
            slip_a = (k == 0);
            @(negedge mgtclk);
            slip_b = 1'b0;
            slip_a = 1'b0;
            @(negedge mgtclk);
            if (k == 30) chk("slip_b_31", {27'b0, slip_b_val}, 32'd31);
        end
        chk("slip_b_wrap", {27'b0, slip_b_val}, 32'd0);
        chk("slip_a_simul", {27'b0, slip_a_val}, 32'd1);

        chk("scoreboard_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sp3_mux_tx.md
SP3_MUX_TX -- requirements
Module: sp3_mux_tx

Interface — parameters (name, default, meaning)
REQ-001 IDLE_A, 32'h0000_0000, word transmitted on stream A when no pair is buffered at a load.
REQ-002 IDLE_B, 32'h0000_0000, word transmitted on stream B when no pair is buffered at a load.

Interface — ports (name, direction, width, meaning)
REQ-003 mgtclk  in  1  single clock, MGT TX user clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 word_a  in  32  stream A lpGBT frame word.
REQ-006 word_b  in  32  stream B lpGBT frame word.
REQ-007 word_valid  in  1  word_a/word_b pair offered.
REQ-008 word_ready  out  1  pair accepted on an edge where word_valid && word_ready.
REQ-009 slip_a  in  1  rising edge requests one extra bit of delay on stream A.
REQ-010 slip_b  in  1  same for stream B.
REQ-011 mgtword  out  32  interleaved word to MGT TX, registered.
REQ-012 tx_phase  out  1  current phase: 0 = next edge loads a pair.
REQ-013 slip_a_val, slip_b_val  out  5 each  current requested bit delay.
REQ-014 underflow_count  out  16  number of loads that used IDLE words, saturating.

Function
REQ-015 A 2-entry FIFO shall hold accepted pairs; word_ready = (occupancy < 2), derived from registered occupancy only.
REQ-016 tx_phase shall toggle on every edge out of reset, starting at 0.
REQ-017 On an edge with tx_phase==0: prev_a<=cur_a, prev_b<=cur_b; cur_a/cur_b <= FIFO head, popped, or IDLE_A/IDLE_B if empty; act_a<=slip_a_val and act_b<=slip_b_val.
REQ-018 An empty-FIFO load shall increment underflow_count, holding at 16'hFFFF.
REQ-019 A push and a pop on the same edge are both performed. A push into an empty FIFO at a phase-0 edge is not popped until the next phase-0 edge.
REQ-020 Slipped words: Ha={prev_a,cur_a} (prev_a in [63:32]); sa=Ha[31+act_a : act_a]. sb is formed the same way from stream B with act_b. With act=0, sa=cur_a.
REQ-021 On an edge with tx_phase==1: mgtword[2i]<=sa[i] and mgtword[2i+1]<=sb[i], for i=0..15.
REQ-022 On an edge with tx_phase==0: mgtword[2i]<=sa[16+i] and mgtword[2i+1]<=sb[16+i], for i=0..15. These use values before that edge's load.
REQ-023 Latency: a pair loaded at edge k appears as its low half at edge k+1 and as its high half at edge k+2.
REQ-024 slip_x is registered. When slip_x is high and was low on the previous edge, slip_x_val increments modulo 32 (31->0).
REQ-025 A held-high slip_x counts once.
REQ-026 A new slip value takes effect only at the next phase-0 load, so an in-flight word is never torn.
REQ-027 Slip on A and B is independent; simultaneous requests both apply.
REQ-028 FIFO order shall be preserved; no pair is dropped or duplicated under backpressure.

Reset
REQ-029 While reset is high, the following shall be cleared on the edge:
- mgtword=0, tx_phase=0, FIFO flushed (word_ready=1 after reset);
- cur/prev registers=0, act_a/act_b=0;
- slip_a_val=slip_b_val=0, underflow_count=0, slip edge registers=0.
REQ-030 Reset asserted mid-frame shall discard all in-flight and buffered data; no partial word is emitted after reset.

Verification
REQ-031 Push a=32'h0000FFFF, b=0 right after reset -> mgtword 32'h55555555 then 32'h00000000 on consecutive edges.
REQ-032 Push a=0, b=32'hFFFFFFFF -> mgtword 32'hAAAAAAAA for both halves.
REQ-033 Underflow:
- Stimulus: no word_valid for 8 edges after reset, defaults IDLE_A/IDLE_B.
- Response: mgtword stays 0; underflow_count=4.
REQ-034 Slip:
- Stimulus: one slip_a pulse, then pairs (a=1,b=0) and (a=0,b=0).
- Response: slip_a_val=1; first pair emits 0,0; second pair's high half = 32'h40000000 (bit 30).
REQ-035 Backpressure:
- Stimulus: hold word_valid with 5 distinct pairs.
- Response: word_ready drops at occupancy 2; all 5 pairs are emitted in order, none lost.
REQ-036 Reset mid-frame and slip wrap:
- Assert reset between the two halves -> next mgtword is 0 and tx_phase=0.
- 32 slip_b pulses -> slip_b_val returns to 0.
